// File: rtl/cv32e40s_hardened_reg_chk.sv
// Check side of a dual-rail hardened register: holds a true copy and a complement copy,
// verifies them every cycle and escalates persistent mismatches to a terminal locked state.
module cv32e40s_hardened_reg_chk #(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] RESVAL = '0,
  parameter int unsigned      THRESH = 2,
  parameter int unsigned      CNT_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_ready_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  input  logic [WIDTH-1:0] flip_i,
  input  logic             clear_minor_i,
  output logic             alert_minor_o,
  output logic             alert_major_o,
  output logic [CNT_W-1:0] mm_cnt_o
);

  typedef enum logic [1:0] {StIdle, StVerify, StLocked} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] q_n_q, q_n_d;
  logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;
  logic             minor_q, minor_d;
  logic             major_q, major_d;

  logic             mismatch;
  logic             wr_hs;
  logic             thresh_hit;
  logic [CNT_W:0]   cnt_inc;

  assign mismatch   = (q_q != ~q_n_q);
  assign wr_hs      = wr_valid_i & wr_ready_o;
  assign cnt_inc    = {1'b0, mm_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  // A write in the same cycle restarts the check, so it masks escalation.
  assign thresh_hit = mismatch & ~wr_hs & (cnt_inc == (CNT_W+1)'(THRESH));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StVerify;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (wr_hs) begin
          state_d = StVerify;
        end else if (thresh_hit) begin
          state_d = StLocked;
        end
      end
      StVerify: state_d = thresh_hit ? StLocked : StIdle;
      StLocked: state_d = StLocked;
      // Corrupted state encoding is treated as a fault.
      default:  state_d = StLocked;
    endcase
  end

  // Outputs
  always_comb begin
    wr_ready_o = (state_q == StIdle);
    rd_valid_o = (state_q == StIdle) & ~mismatch;
    rd_data_o  = (state_q == StLocked) ? RESVAL : q_q;
  end

  // Datapath and alert next-state
  always_comb begin
    q_d      = q_q;
    q_n_d    = q_n_q ^ flip_i;
    mm_cnt_d = '0;
    if (wr_hs) begin
      q_d   = wr_data_i;
      q_n_d = ~wr_data_i ^ flip_i;
    end else if (mismatch) begin
      mm_cnt_d = (&mm_cnt_q) ? mm_cnt_q : cnt_inc[CNT_W-1:0];
    end
    minor_d = mismatch | (minor_q & ~clear_minor_i);
    major_d = major_q | thresh_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q      <= RESVAL;
      q_n_q    <= ~RESVAL;
      mm_cnt_q <= '0;
      minor_q  <= 1'b0;
      major_q  <= 1'b0;
    end else begin
      q_q      <= q_d;
      q_n_q    <= q_n_d;
      mm_cnt_q <= mm_cnt_d;
      minor_q  <= minor_d;
      major_q  <= major_d;
    end
  end

  assign alert_minor_o = minor_q;
  assign alert_major_o = major_q;
  assign mm_cnt_o      = mm_cnt_q;

endmodule

// File: tb/tb_cv32e40s_hardened_reg_chk.sv
// Bench for cv32e40s_hardened_reg_chk: directed scenarios plus random traffic checked
// against a cycle-level behavioural model.
module tb_cv32e40s_hardened_reg_chk;

  localparam int unsigned      WIDTH  = 32;
  localparam logic [WIDTH-1:0] RESVAL = '0;
  localparam int unsigned      THRESH = 2;
  localparam int unsigned      CNT_W  = 3;
  localparam int               MIdle = 0, MVerify = 1, MLocked = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_valid_i = 1'b0;
  logic [WIDTH-1:0] wr_data_i = '0;
  logic             wr_ready_o;
  logic [WIDTH-1:0] rd_data_o;
  logic             rd_valid_o;
  logic [WIDTH-1:0] flip_i = '0;
  logic             clear_minor_i = 1'b0;
  logic             alert_minor_o;
  logic             alert_major_o;
  logic [CNT_W-1:0] mm_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  logic [WIDTH-1:0] mq, mqn;
  int               mst, mrun;
  bit               mminor, mmajor;

  cv32e40s_hardened_reg_chk #(
    .WIDTH (WIDTH),
    .RESVAL(RESVAL),
    .THRESH(THRESH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid_i   (wr_valid_i),
    .wr_data_i    (wr_data_i),
    .wr_ready_o   (wr_ready_o),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .flip_i       (flip_i),
    .clear_minor_i(clear_minor_i),
    .alert_minor_o(alert_minor_o),
    .alert_major_o(alert_major_o),
    .mm_cnt_o     (mm_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    mq = RESVAL; mqn = ~RESVAL; mst = MVerify; mrun = 0; mminor = 0; mmajor = 0;
  endfunction

  function automatic bit model_mm();
    return mq != ~mqn;
  endfunction

  // One clock of the register as described: write, else drift by flip and count mismatches.
  function automatic void model_step(bit wv, logic [WIDTH-1:0] wd, logic [WIDTH-1:0] fl,
                                     bit clr);
    bit mm  = model_mm();
    int run = mrun;
    if (mm) mminor = 1;
    else if (clr) mminor = 0;
    if (mst == MIdle && wv) begin
      mq = wd; mqn = ~wd ^ fl; mrun = 0; mst = MVerify;
    end else begin
      mqn = mqn ^ fl;
      mrun = mm ? ((run + 1 > (1 << CNT_W) - 1) ? run : run + 1) : 0;
      if (mm && run + 1 == int'(THRESH)) begin
        mmajor = 1;
        mst = MLocked;
      end else if (mst == MVerify) begin
        mst = MIdle;
      end
    end
  endfunction

  function automatic logic [WIDTH+CNT_W+3:0] model_outs();
    logic [WIDTH-1:0] d = (mst == MLocked) ? RESVAL : mq;
    return {d, (mst == MIdle) && !model_mm(), mst == MIdle, mminor, mmajor, CNT_W'(mrun)};
  endfunction

  function automatic logic [WIDTH+CNT_W+3:0] dut_outs();
    return {rd_data_o, rd_valid_o, wr_ready_o, alert_minor_o, alert_major_o, mm_cnt_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(wr_valid_i, wr_data_i, flip_i, clear_minor_i);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_valid_i = 0; flip_i = '0; clear_minor_i = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({wr_ready_o, rd_valid_o, rd_data_o, alert_minor_o, alert_major_o, mm_cnt_o} !==
        {2'b00, RESVAL, 2'b00, CNT_W'(0)})
      $display("FAIL reset_held: got rdy=%b vld=%b data=%h min=%b maj=%b cnt=%0d want all 0",
               wr_ready_o, rd_valid_o, rd_data_o, alert_minor_o, alert_major_o, mm_cnt_o);
    else n_pass++;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({wr_ready_o, rd_valid_o} !== 2'b00)
      $display("FAIL reset_verify: got rdy=%b vld=%b want 0 0", wr_ready_o, rd_valid_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({wr_ready_o, rd_valid_o, rd_data_o, alert_minor_o, alert_major_o} !==
        {2'b11, RESVAL, 2'b00})
      $display("FAIL reset_idle: got rdy=%b vld=%b data=%h min=%b maj=%b want 1 1 0 0 0",
               wr_ready_o, rd_valid_o, rd_data_o, alert_minor_o, alert_major_o);
    else n_pass++;
  endtask

  task automatic test_write();
    wr_valid_i = 1; wr_data_i = 32'hA5A5_0F0F;
    tick();
    wr_valid_i = 0; wr_data_i = $urandom;
    n_checks++;
    if ({rd_data_o, wr_ready_o, rd_valid_o} !== {32'hA5A5_0F0F, 2'b00})
      $display("FAIL write_lat1: got data=%h rdy=%b vld=%b want a5a50f0f 0 0",
               rd_data_o, wr_ready_o, rd_valid_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({rd_data_o, wr_ready_o, rd_valid_o} !== {32'hA5A5_0F0F, 2'b11})
      $display("FAIL write_lat2: got data=%h rdy=%b vld=%b want a5a50f0f 1 1",
               rd_data_o, wr_ready_o, rd_valid_o);
    else n_pass++;
  endtask

  task automatic test_lock();
    flip_i = 32'h1;
    tick();
    flip_i = '0;
    n_checks++;
    if ({rd_valid_o, wr_ready_o, alert_minor_o, mm_cnt_o} !== {3'b010, CNT_W'(0)})
      $display("FAIL lock_c0: got vld=%b rdy=%b min=%b cnt=%0d want 0 1 0 0",
               rd_valid_o, wr_ready_o, alert_minor_o, mm_cnt_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({alert_minor_o, alert_major_o, mm_cnt_o, wr_ready_o} !== {2'b10, CNT_W'(1), 1'b1})
      $display("FAIL lock_c1: got min=%b maj=%b cnt=%0d rdy=%b want 1 0 1 1",
               alert_minor_o, alert_major_o, mm_cnt_o, wr_ready_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({alert_major_o, wr_ready_o, rd_valid_o, rd_data_o, mm_cnt_o} !==
        {3'b100, RESVAL, CNT_W'(THRESH)})
      $display("FAIL lock_c2: got maj=%b rdy=%b vld=%b data=%h cnt=%0d want 1 0 0 0 2",
               alert_major_o, wr_ready_o, rd_valid_o, rd_data_o, mm_cnt_o);
    else n_pass++;
    wr_valid_i = 1; wr_data_i = 32'h1234_5678;
    tick();
    wr_valid_i = 0;
    n_checks++;
    if ({alert_major_o, wr_ready_o, rd_data_o} !== {2'b10, RESVAL})
      $display("FAIL lock_sticky: got maj=%b rdy=%b data=%h want 1 0 0",
               alert_major_o, wr_ready_o, rd_data_o);
    else n_pass++;
  endtask

  // Asynchronous reset while locked or verifying, then a normal write.
  task automatic test_async_reset(input bool_verify);
    logic [WIDTH-1:0] d = $urandom;
    if (bool_verify) begin
      wr_valid_i = 1; wr_data_i = $urandom;
      tick();
      wr_valid_i = 0;
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({wr_ready_o, rd_valid_o, rd_data_o, alert_minor_o, alert_major_o, mm_cnt_o} !==
        {2'b00, RESVAL, 2'b00, CNT_W'(0)})
      $display("FAIL async_rst%0d: got rdy=%b vld=%b data=%h min=%b maj=%b cnt=%0d want 0",
               bool_verify, wr_ready_o, rd_valid_o, rd_data_o, alert_minor_o,
               alert_major_o, mm_cnt_o);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    wr_valid_i = 1; wr_data_i = d;
    tick();
    wr_valid_i = 0;
    tick();
    n_checks++;
    if ({rd_data_o, rd_valid_o, wr_ready_o} !== {d, 2'b11})
      $display("FAIL post_rst_write%0d: got data=%h vld=%b rdy=%b want %h 1 1",
               bool_verify, rd_data_o, rd_valid_o, wr_ready_o, d);
    else n_pass++;
  endtask

  task automatic test_heal();
    flip_i = 32'h1;
    tick();
    tick();
    flip_i = '0;
    n_checks++;
    if ({alert_minor_o, mm_cnt_o, rd_valid_o} !== {1'b1, CNT_W'(1), 1'b1})
      $display("FAIL heal_c1: got min=%b cnt=%0d vld=%b want 1 1 1",
               alert_minor_o, mm_cnt_o, rd_valid_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({alert_minor_o, alert_major_o, mm_cnt_o} !== {2'b10, CNT_W'(0)})
      $display("FAIL heal_c2: got min=%b maj=%b cnt=%0d want 1 0 0",
               alert_minor_o, alert_major_o, mm_cnt_o);
    else n_pass++;
    clear_minor_i = 1;
    tick();
    clear_minor_i = 0;
    n_checks++;
    if (alert_minor_o !== 1'b0)
      $display("FAIL minor_clear: got %b want 0", alert_minor_o);
    else n_pass++;
    flip_i = 32'h1;
    tick();
    clear_minor_i = 1;
    tick();
    flip_i = '0; clear_minor_i = 0;
    n_checks++;
    if ({alert_minor_o, mm_cnt_o} !== {1'b1, CNT_W'(1)})
      $display("FAIL minor_set_wins: got min=%b cnt=%0d want 1 1", alert_minor_o, mm_cnt_o);
    else n_pass++;
  endtask

  task automatic test_write_flip();
    wr_valid_i = 1; wr_data_i = $urandom; flip_i = 32'h4;
    tick();
    wr_valid_i = 0; flip_i = '0;
    n_checks++;
    if ({wr_ready_o, mm_cnt_o, alert_minor_o} !== {1'b0, CNT_W'(0), 1'b0})
      $display("FAIL wflip_verify: got rdy=%b cnt=%0d min=%b want 0 0 0",
               wr_ready_o, mm_cnt_o, alert_minor_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({alert_minor_o, mm_cnt_o, rd_valid_o, alert_major_o} !== {1'b1, CNT_W'(1), 2'b00})
      $display("FAIL wflip_detect: got min=%b cnt=%0d vld=%b maj=%b want 1 1 0 0",
               alert_minor_o, mm_cnt_o, rd_valid_o, alert_major_o);
    else n_pass++;
  endtask

  task automatic test_random();
    int locked_for = 0;
    for (int i = 0; i < 400; i++) begin
      wr_valid_i    = ($urandom_range(0, 2) == 0);
      wr_data_i     = $urandom;
      flip_i        = ($urandom_range(0, 9) == 0) ? (32'h1 << $urandom_range(0, WIDTH - 1)) : '0;
      clear_minor_i = ($urandom_range(0, 7) == 0);
      tick();
      n_checks++;
      if (dut_outs() !== model_outs())
        $display("FAIL random_%0d: got %h want %h", i, dut_outs(), model_outs());
      else n_pass++;
      locked_for = (mst == MLocked) ? locked_for + 1 : 0;
      if (locked_for > 3) begin
        do_reset();
        locked_for = 0;
      end
    end
    wr_valid_i = 0; flip_i = '0; clear_minor_i = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write();
    test_lock();
    test_async_reset(1'b0);
    test_async_reset(1'b1);
    do_reset();
    test_heal();
    do_reset();
    test_write_flip();
    do_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
